// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle between one master port and a register-bank slave.
interface axil_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
    logic                    s_axi_awvalid;
    logic                    s_axi_awready;
    logic [DATA_WIDTH-1:0]   s_axi_wdata;
    logic [DATA_WIDTH/8:0]   s_axi_wstrb;
    logic                    s_axi_wvalid;
    logic                    s_axi_wready;
    logic [RESP_WIDTH-1:0]   s_axi_bresp;
    logic                    s_axi_bvalid;
    logic                    s_axi_bready;
    logic [ADDR_WIDTH-1:0]   s_axi_araddr;
    logic                    s_axi_arvalid;
    logic                    s_axi_arready;
    logic [DATA_WIDTH-1:0]   s_axi_rdata;
    logic [RESP_WIDTH-1:0]   s_axi_rresp;
    logic                    s_axi_rvalid;
    logic                    s_axi_rready;

    modport slave (
        input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );

    modport master (
        output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
               s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
        input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
               s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register bank: NUM_REGS-1 read/write words plus a read-only
// write counter (STATUS) in the top slot of a fixed address window.
module axil_reg_slave #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    RESP_WIDTH = 3,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 8'h10
) (
    input  logic     s_axi_aclk,
    input  logic     s_axi_areset,
    axil_if.slave    bus
);
    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int DEC_W  = IDX_W + 2;
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OKAY   = RESP_WIDTH'(0);
    localparam logic [RESP_WIDTH-1:0] RESP_SLVERR = RESP_WIDTH'(2);
    localparam logic [IDX_W-1:0]      STATUS_IDX  = IDX_W'(NUM_REGS - 1);

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

    // Upper address bits select the window; the word index sits below them.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:DEC_W] upper);
        return upper == BASE_ADDR[ADDR_WIDTH-1:DEC_W];
    endfunction

    // Replace only the strobed bytes of the old word.
    function automatic logic [DATA_WIDTH-1:0] byte_merge(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) begin
                res[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                res[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return res;
    endfunction

    // Slot NUM_REGS-1 of the array holds the write count (STATUS).
    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    wstate_e                 wstate_q, wstate_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic [ADDR_WIDTH-1:2]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    bvalid_q, bvalid_d;
    logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;
    rstate_e                 rstate_q, rstate_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;
    logic [IDX_W-1:0]        widx_s, ridx_s;
    logic                    unused_bits_s;

    assign widx_s = awaddr_q[DEC_W-1:2];
    assign ridx_s = bus.s_axi_araddr[DEC_W-1:2];
    // Byte offset and the extra strobe bit carry no meaning here.
    assign unused_bits_s = ^{bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0],
                             bus.s_axi_wstrb[STRB_W]};

    // Write path: independent AW/W capture, commit one cycle after both, then hold B.
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        case (wstate_q)
            W_IDLE: begin
                if (awready_q && bus.s_axi_awvalid) begin
                    awready_d = 1'b0;
                    awaddr_d  = bus.s_axi_awaddr[ADDR_WIDTH-1:2];
                end else begin
                    awaddr_d  = awaddr_q;
                end
                if (wready_q && bus.s_axi_wvalid) begin
                    wready_d = 1'b0;
                    wdata_d  = bus.s_axi_wdata;
                    wstrb_d  = bus.s_axi_wstrb[STRB_W-1:0];
                end else begin
                    wdata_d  = wdata_q;
                end
                // Both readies low in idle means address and data are captured.
                if (!awready_q && !wready_q) begin
                    if (addr_hit(awaddr_q[ADDR_WIDTH-1:DEC_W]) && (widx_s != STATUS_IDX)) begin
                        regs_d[widx_s]     = byte_merge(regs_q[widx_s], wdata_q, wstrb_q);
                        regs_d[NUM_REGS-1] = regs_q[NUM_REGS-1] + DATA_WIDTH'(1);
                        bresp_d            = RESP_OKAY;
                    end else begin
                        bresp_d            = RESP_SLVERR;
                    end
                    bvalid_d = 1'b1;
                    wstate_d = W_RESP;
                end else begin
                    wstate_d = W_IDLE;
                end
            end
            W_RESP: begin
                if (bus.s_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    wstate_d  = W_IDLE;
                end else begin
                    wstate_d  = W_RESP;
                end
            end
            default: begin
                wstate_d  = W_IDLE;
                bvalid_d  = 1'b0;
                awready_d = 1'b1;
                wready_d  = 1'b1;
            end
        endcase
    end

    // Write-side state, capture buffers and the register array.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read path: sample the array at the AR handshake, hold R until accepted.
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (arready_q && bus.s_axi_arvalid) begin
                    if (addr_hit(bus.s_axi_araddr[ADDR_WIDTH-1:DEC_W])) begin
                        rdata_d = regs_q[ridx_s];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rstate_d  = R_DATA;
                end else begin
                    rstate_d  = R_IDLE;
                end
            end
            R_DATA: begin
                if (bus.s_axi_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    rstate_d  = R_IDLE;
                end else begin
                    rstate_d  = R_DATA;
                end
            end
            default: begin
                rstate_d  = R_IDLE;
                rvalid_d  = 1'b0;
                arready_d = 1'b1;
            end
        endcase
    end

    // Read-side state and registered R channel.
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign bus.s_axi_awready = awready_q;
    assign bus.s_axi_wready  = wready_q;
    assign bus.s_axi_bvalid  = bvalid_q;
    assign bus.s_axi_bresp   = bresp_q;
    assign bus.s_axi_arready = arready_q;
    assign bus.s_axi_rvalid  = rvalid_q;
    assign bus.s_axi_rdata   = rdata_q;
    assign bus.s_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed vector table, handshake
// corner sequences and randomized traffic against a word-level model.
module tb_axil_reg_slave;
    logic clk;
    logic areset;
    int   checks;
    int   failures;

    axil_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3)) bus ();

    axil_reg_slave #(
        .DATA_WIDTH(32), .ADDR_WIDTH(8), .RESP_WIDTH(3),
        .NUM_REGS(4), .BASE_ADDR(8'h10)
    ) dut (
        .s_axi_aclk   (clk),
        .s_axi_areset (areset),
        .bus          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: three data words and a write counter.
    logic [31:0] m_regs [3];
    logic [31:0] m_count;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [4:0]  strb;
        logic [2:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [7:0] a);
        return a[7:4] == 4'h1;
    endfunction

    function automatic logic [2:0] m_wresp(input logic [7:0] a);
        return (m_hit(a) && a[3:2] != 2'd3) ? 3'd0 : 3'd2;
    endfunction

    function automatic logic [31:0] m_rdata(input logic [7:0] a);
        if (!m_hit(a)) return 32'd0;
        if (a[3:2] == 2'd3) return m_count;
        return m_regs[a[3:2]];
    endfunction

    task automatic m_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s);
        if (m_wresp(a) == 3'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (s[i]) m_regs[a[3:2]][i*8 +: 8] = d[i*8 +: 8];
            end
            m_count = m_count + 32'd1;
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 3; i++) m_regs[i] = 32'd0;
        m_count = 32'd0;
    endtask

    // Full write transaction; called and returns at #1 after a rising edge.
    task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [4:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [2:0] resp);
        bit aw_done, w_done, hs_aw, hs_w;
        int cyc;
        logic [2:0] exp;
        exp = m_wresp(addr);
        aw_done = 1'b0; w_done = 1'b0; cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            if (!aw_done && cyc >= aw_dly) begin bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin
                bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = data; bus.s_axi_wstrb = strb;
            end
            if (aw_done) chk("awready_after_aw", 32'(bus.s_axi_awready), 32'd0);
            if (w_done)  chk("wready_after_w", 32'(bus.s_axi_wready), 32'd0);
            chk("bvalid_before_aw_w", 32'(bus.s_axi_bvalid), 32'd0);
            hs_aw = bus.s_axi_awvalid && bus.s_axi_awready;
            hs_w  = bus.s_axi_wvalid && bus.s_axi_wready;
            @(posedge clk); #1;
            if (hs_aw) begin aw_done = 1'b1; bus.s_axi_awvalid = 1'b0; end
            if (hs_w)  begin w_done = 1'b1; bus.s_axi_wvalid = 1'b0; end
            cyc++;
        end
        chk("aw_w_handshake_timeout", 32'(aw_done && w_done), 32'd1);
        chk("bvalid_latency_early", 32'(bus.s_axi_bvalid), 32'd0);
        @(posedge clk); #1;
        chk("bvalid_latency", 32'(bus.s_axi_bvalid), 32'd1);
        resp = bus.s_axi_bresp;
        chk("bresp_model", 32'(resp), 32'(exp));
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            chk("bvalid_hold", 32'(bus.s_axi_bvalid), 32'd1);
            chk("bresp_hold", 32'(bus.s_axi_bresp), 32'(resp));
            chk("awready_in_resp", 32'(bus.s_axi_awready), 32'd0);
            chk("wready_in_resp", 32'(bus.s_axi_wready), 32'd0);
        end
        bus.s_axi_bready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_bready = 1'b0;
        chk("bvalid_clear", 32'(bus.s_axi_bvalid), 32'd0);
        chk("awready_reopen", 32'(bus.s_axi_awready), 32'd1);
        chk("wready_reopen", 32'(bus.s_axi_wready), 32'd1);
        m_write(addr, data, strb);
    endtask

    // Full read transaction; data and response compared against the model.
    task automatic do_read(input logic [7:0] addr, input int r_dly,
                           output logic [31:0] data, output logic [2:0] resp);
        bit hs;
        int cyc;
        logic [31:0] exp_d;
        logic [2:0] exp_r;
        exp_d = m_rdata(addr);
        exp_r = m_hit(addr) ? 3'd0 : 3'd2;
        hs = 1'b0; cyc = 0;
        bus.s_axi_arvalid = 1'b1; bus.s_axi_araddr = addr;
        while (!hs && cyc < 50) begin
            hs = bus.s_axi_arready;
            @(posedge clk); #1;
            cyc++;
        end
        bus.s_axi_arvalid = 1'b0;
        chk("ar_handshake_timeout", 32'(hs), 32'd1);
        chk("rvalid_latency", 32'(bus.s_axi_rvalid), 32'd1);
        chk("arready_in_rdata", 32'(bus.s_axi_arready), 32'd0);
        data = bus.s_axi_rdata;
        resp = bus.s_axi_rresp;
        chk("rdata_model", data, exp_d);
        chk("rresp_model", 32'(resp), 32'(exp_r));
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            chk("rvalid_hold", 32'(bus.s_axi_rvalid), 32'd1);
            chk("rdata_hold", bus.s_axi_rdata, data);
            chk("arready_hold_low", 32'(bus.s_axi_arready), 32'd0);
        end
        bus.s_axi_rready = 1'b1;
        @(posedge clk); #1;
        bus.s_axi_rready = 1'b0;
        chk("rvalid_clear", 32'(bus.s_axi_rvalid), 32'd0);
        chk("arready_reopen", 32'(bus.s_axi_arready), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [2:0]  rs;
        logic [7:0]  a;
        int          tmo;
        checks = 0; failures = 0;
        bus.s_axi_awaddr = 8'h00; bus.s_axi_awvalid = 1'b0;
        bus.s_axi_wdata = 32'h0; bus.s_axi_wstrb = 5'h0; bus.s_axi_wvalid = 1'b0;
        bus.s_axi_bready = 1'b0;
        bus.s_axi_araddr = 8'h00; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;
        m_reset();

        vecs.push_back('{1'b1, 8'h10, 32'd56,        5'h0F, 3'd0, 32'd0});
        vecs.push_back('{1'b0, 8'h10, 32'd0,         5'h00, 3'd0, 32'd56});
        vecs.push_back('{1'b0, 8'h1C, 32'd0,         5'h00, 3'd0, 32'd1});
        vecs.push_back('{1'b1, 8'h14, 32'h11223344,  5'h0F, 3'd0, 32'd0});
        vecs.push_back('{1'b1, 8'h14, 32'hAABBCCDD,  5'h05, 3'd0, 32'd0});
        vecs.push_back('{1'b0, 8'h14, 32'd0,         5'h00, 3'd0, 32'h11BB33DD});
        vecs.push_back('{1'b0, 8'h24, 32'd0,         5'h00, 3'd2, 32'd0});
        vecs.push_back('{1'b1, 8'h1C, 32'hDEADBEEF,  5'h0F, 3'd2, 32'd0});
        vecs.push_back('{1'b0, 8'h1C, 32'd0,         5'h00, 3'd0, 32'd3});
        vecs.push_back('{1'b1, 8'h00, 32'h12345678,  5'h0F, 3'd2, 32'd0});
        vecs.push_back('{1'b0, 8'h10, 32'd0,         5'h00, 3'd0, 32'd56});
        vecs.push_back('{1'b0, 8'h1F, 32'd0,         5'h00, 3'd0, 32'd3});
        vecs.push_back('{1'b1, 8'h18, 32'hFFFFFFFF,  5'h10, 3'd0, 32'd0});
        vecs.push_back('{1'b0, 8'h18, 32'd0,         5'h00, 3'd0, 32'd0});
        vecs.push_back('{1'b0, 8'h1C, 32'd0,         5'h00, 3'd0, 32'd4});
        vecs.push_back('{1'b1, 8'h1B, 32'h0000A5A5,  5'h03, 3'd0, 32'd0});
        vecs.push_back('{1'b0, 8'h18, 32'd0,         5'h00, 3'd0, 32'h0000A5A5});

        // Reset state after the reset edge.
        areset = 1'b1;
        @(posedge clk); #1;
        chk("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
        chk("rst_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("rst_wready", 32'(bus.s_axi_wready), 32'd1);
        chk("rst_arready", 32'(bus.s_axi_arready), 32'd1);
        chk("rst_rdata", bus.s_axi_rdata, 32'd0);
        chk("rst_bresp", 32'(bus.s_axi_bresp), 32'd0);
        chk("rst_rresp", 32'(bus.s_axi_rresp), 32'd0);
        areset = 1'b0;
        @(posedge clk); #1;

        // Directed vector table.
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, rs);
                chk($sformatf("vec%0d_bresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end else begin
                do_read(vecs[i].addr, 0, rd, rs);
                chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
                chk($sformatf("vec%0d_rresp", i), 32'(rs), 32'(vecs[i].exp_resp));
            end
        end

        // W arrives two cycles after AW: no response before the data.
        do_write(8'h14, 32'h01020304, 5'h0A, 0, 2, 0, rs);
        do_read(8'h14, 0, rd, rs);
        chk("late_w_merge", rd, 32'h01BB03DD);
        // AW after W.
        do_write(8'h10, 32'hCAFEF00D, 5'h0F, 3, 1, 0, rs);
        // Back-pressure on B and on R.
        do_write(8'h10, 32'h00000077, 5'h01, 0, 0, 5, rs);
        do_read(8'h18, 4, rd, rs);
        chk("rready_stall_data", rd, 32'h0000A5A5);

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) != 0) a = 8'h10 | 8'($urandom_range(0, 15));
            else a = 8'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), rs);
            else
                do_read(a, $urandom_range(0, 3), rd, rs);
        end

        // Reset while a write response is pending drops it silently.
        bus.s_axi_awvalid = 1'b1; bus.s_axi_awaddr = 8'h10;
        bus.s_axi_wvalid = 1'b1; bus.s_axi_wdata = 32'h99; bus.s_axi_wstrb = 5'h0F;
        @(posedge clk); #1;
        bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0;
        tmo = 0;
        while (!bus.s_axi_bvalid && tmo < 10) begin
            @(posedge clk); #1;
            tmo++;
        end
        chk("pre_reset_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
        areset = 1'b1;
        @(posedge clk); #1;
        areset = 1'b0;
        m_reset();
        chk("midrst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        chk("midrst_awready", 32'(bus.s_axi_awready), 32'd1);
        chk("midrst_wready", 32'(bus.s_axi_wready), 32'd1);
        chk("midrst_arready", 32'(bus.s_axi_arready), 32'd1);
        @(posedge clk); #1;
        chk("post_rst_no_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
        do_read(8'h10, 0, rd, rs);
        chk("post_rst_reg0", rd, 32'd0);
        do_read(8'h1C, 0, rd, rs);
        chk("post_rst_count", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
